pc_redirect_unit: RTL
=====================

// Module: pc_redirect_unit
// PURPOSE
//  Fetch-side consumer of the branch history table's prediction/correction outputs.
//  Owns the architectural fetch PC and selects the next PC from the BHT outputs.
//  Carries PC and prediction bit through the IF->ID->EXE pipeline with valid bits.
//  Raises the flush, squashes wrong-path stages and counts resolved/mispredicted branches.
// PARAMETERS
//  ADDR_W    10      PC width in bits, byte address, same width as the BHT PC ports
//  RESET_PC  10'h000 fetch PC loaded on reset
//  CNT_W     16      width of the saturating statistics counters
// PORTS
//  CLK             in   1       clock, all state on rising edge
//  nrst            in   1       reset, asynchronous, active-low
//  stall           in   1       ID hazard stall: hold IF/ID, insert bubble into EXE
//  if_prediction   in   1       BHT predicts taken for if_PC
//  if_PBT          in   ADDR_W  predicted branch target for if_PC
//  exe_correction  in   2       BHT correction: 2'b10 -> go to exe_CNI, 2'b11 -> go to exe_PBT
//  exe_CNI         in   ADDR_W  correct next instruction (not-taken path)
//  exe_PBT         in   ADDR_W  taken target for the EXE branch
//  exe_is_btype    in   1       EXE instruction is a conditional branch
//  if_PC           out  ADDR_W  current fetch PC, driven to BHT and I-mem
//  id_PC, exe_PC   out  ADDR_W  PC of instruction in ID / EXE
//  id_pred         out  1       prediction bit carried with the ID instruction
//  exe_pred        out  1       prediction bit carried with the EXE instruction
//  id_valid        out  1       ID holds a live instruction
//  exe_valid       out  1       EXE holds a live instruction
//  flush           out  1       accepted correction this cycle (combinational)
//  branch_cnt      out  CNT_W   resolved conditional branches, saturating
//  mispred_cnt     out  CNT_W   accepted corrections, saturating
// BEHAVIOUR
//  Reset (async, nrst=0): if_PC=RESET_PC; id_PC=exe_PC=0; id_pred=exe_pred=0;
//   id_valid=exe_valid=0; both counters 0. flush=0 during reset.
//  Accept: corr_ok = exe_correction[1] & exe_valid; flush = corr_ok. Correction with
//   exe_valid=0 is ignored entirely (no redirect, no count).
//  Next-PC priority (registered into if_PC each edge):
//   1. corr_ok: exe_correction[0] ? exe_PBT : exe_CNI   (stall is overridden)
//   2. stall: hold if_PC
//   3. if_prediction: if_PBT
//   4. else if_PC + 4, truncated to ADDR_W (wraps 2^ADDR_W-4 -> 0)
//  Stage update, one edge:
//   corr_ok: id_valid<=0, exe_valid<=0 (IF and ID instructions are wrong-path); PC/pred
//    regs of ID/EXE may take any value but valid=0.
//   else stall: id_* hold; exe_valid<=0, exe_PC/exe_pred hold.
//   else: id_PC<=if_PC, id_pred<=if_prediction, id_valid<=1;
//    exe_PC<=id_PC, exe_pred<=id_pred, exe_valid<=id_valid.
//  Prediction latency: taken if_prediction redirects fetch next cycle (0 bubbles);
//   misprediction costs 2 cycles (two squashed slots).
//  Counters: branch_cnt +1 each cycle with exe_valid & exe_is_btype; mispred_cnt +1
//   on corr_ok. Both stop at 2^CNT_W-1, never wrap. Both may increment same cycle.
//  Invariant: mispred_cnt <= branch_cnt only if corrections accompany branches; the
//   unit does not enforce it (jumps handled upstream never raise exe_correction).
//  Reset mid-operation: all state returns to reset values immediately; first valid
//   id instruction appears one edge after nrst deasserts.
// TESTING
//  1. Reset with RESET_PC=0x000, no predictions: if_PC 0,4,8,..; id_valid=1 after 1
//     edge, exe_valid=1 after 2; exe_PC trails if_PC by 2 fetches.
//  2. Wrap: if_PC=0x3FC, no prediction -> next if_PC=0x000.
//  3. if_prediction=1, if_PBT=0x120 at if_PC=0x040 -> if_PC=0x120 next edge; id_pred=1,
//     then exe_pred=1 with exe_PC=0x040.
//  4. exe_valid=1, exe_is_btype=1, exe_correction=2'b10, exe_CNI=0x048 -> flush=1 same
//     cycle; if_PC=0x048; id_valid=exe_valid=0 next; branch_cnt/mispred_cnt +1.
//  5. Same as 4 but stall=1 and exe_correction=2'b11, exe_PBT=0x200 -> if_PC=0x200
//     regardless of stall; exe_correction=2'b11 with exe_valid=0 -> flush=0, no change.
//  6. Preload-free saturation: 2^CNT_W+3 consecutive mispredicts -> mispred_cnt=all-ones;
//     nrst pulse mid-run -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC owner and next-PC select from BHT outputs, with IF/ID/EXE tracking and branch statistics
module pc_redirect_unit #(
    parameter int                ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              nrst,
    input  logic              stall,
    input  logic              if_prediction,
    input  logic [ADDR_W-1:0] if_PBT,
    input  logic [1:0]        exe_correction,
    input  logic [ADDR_W-1:0] exe_CNI,
    input  logic [ADDR_W-1:0] exe_PBT,
    input  logic              exe_is_btype,
    output logic [ADDR_W-1:0] if_PC,
    output logic [ADDR_W-1:0] id_PC,
    output logic [ADDR_W-1:0] exe_PC,
    output logic              id_pred,
    output logic              exe_pred,
    output logic              id_valid,
    output logic              exe_valid,
    output logic              flush,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              corr_ok;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              branch_inc;

    // A correction only counts when it belongs to a live EXE instruction.
    assign corr_ok     = exe_correction[1] & exe_valid;
    assign flush       = corr_ok;
    assign seq_pc      = if_PC + ADDR_W'(4);
    assign redirect_pc = exe_correction[0] ? exe_PBT : exe_CNI;
    assign branch_inc  = exe_valid & exe_is_btype;

    always_comb begin
        next_pc = seq_pc;
        if (corr_ok) begin
            next_pc = redirect_pc;
        end else if (stall) begin
            next_pc = if_PC;
        end else if (if_prediction) begin
            next_pc = if_PBT;
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            if_PC <= RESET_PC;
        end else begin
            if_PC <= next_pc;
        end
    end

    // IF->ID: a correction squashes the instruction being fetched; a stall freezes ID.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            id_PC    <= '0;
            id_pred  <= 1'b0;
            id_valid <= 1'b0;
        end else if (corr_ok) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_PC    <= if_PC;
            id_pred  <= if_prediction;
            id_valid <= 1'b1;
        end
    end

    // ID->EXE: a stall inserts a bubble while keeping the last EXE PC/pred visible.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            exe_PC    <= '0;
            exe_pred  <= 1'b0;
            exe_valid <= 1'b0;
        end else if (corr_ok || stall) begin
            exe_valid <= 1'b0;
        end else begin
            exe_PC    <= id_PC;
            exe_pred  <= id_pred;
            exe_valid <= id_valid;
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (branch_inc && branch_cnt != CNT_MAX) begin
                branch_cnt <= branch_cnt + 1'b1;
            end
            if (corr_ok && mispred_cnt != CNT_MAX) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

endmodule
